onehot_decoder_stream: RTL and testbench

- Parametrised, registered successor to the team's combinational 4-to-16 binary-to-one-hot decoder.
- Decodes an IN_W-bit index stream into 2**IN_W-bit one-hot words, thermometer words, or accumulated block masks.
- Accumulated masks are OR-accumulated over a group and emitted on the group's last beat.
- Sits between entropy/run-length decode and coefficient storage in the JPEG pipeline; for example, IN_W=6 gives a 64-bit "coefficient present" mask per 8x8 block.
- Uses a valid/ready handshake on both sides with a 2-entry skid buffer, so backpressure never drops data.

---
 rtl/onehot_dec_pkg.sv | 14 +
 rtl/onehot_decoder_stream_if.sv | 32 +++
 rtl/dec_skid_buf.sv | 70 +++++++
 rtl/onehot_decoder_stream.sv | 95 +++++++++
 tb/tb_onehot_decoder_stream.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onehot_dec_pkg.sv
// Shared constants and helpers for the streaming one-hot / thermometer / mask decoder.
package onehot_dec_pkg;

   localparam logic [1:0] MODE_ONEHOT = 2'b00;
   localparam logic [1:0] MODE_THERM  = 2'b01;
   localparam logic [1:0] MODE_ACCUM  = 2'b10;
   localparam logic [1:0] MODE_RSVD   = 2'b11;

   // Decoded word width for a given index width.
   function automatic int unsigned calc_out_w(input int unsigned in_w);
      return 32'd1 << in_w;
   endfunction

endpackage

// File: rtl/onehot_decoder_stream_if.sv
// Valid/ready bus between index producer, decoder and coefficient storage.
interface onehot_decoder_stream_if #(
   parameter int unsigned IN_W  = 4,
   parameter int unsigned CNT_W = IN_W + 1
);
   import onehot_dec_pkg::*;

   localparam int unsigned OUT_W = calc_out_w(IN_W);

   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  in_idx;
   logic             in_last;
   logic [1:0]       mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_word;
   logic [CNT_W-1:0] out_cnt;

   // Environment side: drives beats in, consumes words out.
   modport master (
      output in_valid, in_idx, in_last, mode, out_ready,
      input  in_ready, out_valid, out_word, out_cnt
   );

   // Decoder side.
   modport slave (
      input  in_valid, in_idx, in_last, mode, out_ready,
      output in_ready, out_valid, out_word, out_cnt
   );

endinterface

// File: rtl/dec_skid_buf.sv
// Two-entry output stage (main + skid register) with registered ready; strictly FIFO.
module dec_skid_buf #(
   parameter int unsigned W = 21
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   output logic         ready_o,
   output logic         valid_o,
   input  logic         pop_ready_i,
   output logic [W-1:0] data_o
);

   logic         main_v_q, main_v_d;
   logic [W-1:0] main_q, main_d;
   logic         skid_v_q, skid_v_d;
   logic [W-1:0] skid_q, skid_d;
   logic         ready_q, ready_d;
   logic         main_free;

   // Main accepts whenever it is empty or draining; skid only catches a stalled push.
   always_comb begin
      main_v_d  = main_v_q;
      main_d    = main_q;
      skid_v_d  = skid_v_q;
      skid_d    = skid_q;
      main_free = !main_v_q || pop_ready_i;
      if (main_free) begin
         if (skid_v_q) begin
            main_v_d = 1'b1;
            main_d   = skid_q;
            skid_v_d = push_i;
            if (push_i) begin
               skid_d = data_i;
            end
         end else begin
            main_v_d = push_i;
            if (push_i) begin
               main_d = data_i;
            end
         end
      end else if (push_i) begin
         skid_v_d = 1'b1;
         skid_d   = data_i;
      end
      ready_d = !skid_v_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         main_v_q <= 1'b0;
         main_q   <= '0;
         skid_v_q <= 1'b0;
         skid_q   <= '0;
         ready_q  <= 1'b0;
      end else begin
         main_v_q <= main_v_d;
         main_q   <= main_d;
         skid_v_q <= skid_v_d;
         skid_q   <= skid_d;
         ready_q  <= ready_d;
      end
   end

   assign ready_o = ready_q;
   assign valid_o = main_v_q;
   assign data_o  = main_q;

endmodule

// File: rtl/onehot_decoder_stream.sv
// Registered index decoder: one-hot, thermometer, or OR-accumulated group masks
// with a beat count, behind a two-entry skid buffer.
module onehot_decoder_stream
   import onehot_dec_pkg::*;
#(
   parameter int unsigned IN_W  = 4,
   parameter int unsigned CNT_W = IN_W + 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   onehot_decoder_stream_if.slave  bus
);

   localparam int unsigned OUT_W = calc_out_w(IN_W);
   localparam int unsigned PW    = OUT_W + CNT_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [OUT_W-1:0] mask_q, mask_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [OUT_W-1:0] onehot_w, therm_w, mask_next, word;
   logic [CNT_W-1:0] cnt_inc, word_cnt;
   logic             in_ready, accept, produce;
   logic [PW-1:0]    skid_out;

   assign accept = bus.in_valid && in_ready;

   // Per-beat decodes; the counter saturates instead of wrapping.
   always_comb begin
      onehot_w  = OUT_W'(1) << bus.in_idx;
      therm_w   = ~({OUT_W{1'b1}} << bus.in_idx << 1);
      mask_next = mask_q | onehot_w;
      cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
   end

   // Only accumulate beats touch the group state; other modes pass straight through.
   always_comb begin
      mask_d   = mask_q;
      cnt_d    = cnt_q;
      produce  = 1'b0;
      word     = onehot_w;
      word_cnt = CNT_ONE;
      if (accept) begin
         case (bus.mode)
            MODE_THERM: begin
               produce = 1'b1;
               word    = therm_w;
            end
            MODE_ACCUM: begin
               word     = mask_next;
               word_cnt = cnt_inc;
               if (bus.in_last) begin
                  produce = 1'b1;
                  mask_d  = '0;
                  cnt_d   = '0;
               end else begin
                  mask_d = mask_next;
                  cnt_d  = cnt_inc;
               end
            end
            default: begin
               produce = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mask_q <= '0;
         cnt_q  <= '0;
      end else begin
         mask_q <= mask_d;
         cnt_q  <= cnt_d;
      end
   end

   dec_skid_buf #(
      .W(PW)
   ) u_skid (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (produce),
      .data_i      ({word, word_cnt}),
      .ready_o     (in_ready),
      .valid_o     (bus.out_valid),
      .pop_ready_i (bus.out_ready),
      .data_o      (skid_out)
   );

   assign bus.in_ready = in_ready;
   assign bus.out_word = skid_out[PW-1:CNT_W];
   assign bus.out_cnt  = skid_out[CNT_W-1:0];

endmodule

// File: tb/tb_onehot_decoder_stream.sv
// Self-checking bench: vector table, hand-written corner sequences and a
// randomized stream checked against a queue-based reference model.
module tb_onehot_decoder_stream;

   localparam int unsigned IW  = 4;
   localparam int unsigned CW  = 5;
   localparam int unsigned IW6 = 6;
   localparam int unsigned CW6 = 7;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   onehot_decoder_stream_if #(.IN_W(IW),  .CNT_W(CW))  b4 ();
   onehot_decoder_stream_if #(.IN_W(IW6), .CNT_W(CW6)) b6 ();

   onehot_decoder_stream #(.IN_W(IW), .CNT_W(CW)) dut4 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (b4)
   );

   onehot_decoder_stream #(.IN_W(IW6), .CNT_W(CW6)) dut6 (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (b6)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [15:0] word;
      logic [4:0]  cnt;
   } exp_t;

   exp_t        q[$];
   exp_t        ne, pe;
   logic [15:0] am_mask = '0;
   int          am_cnt  = 0;
   logic        stall_prev = 1'b0;
   logic [20:0] stall_val  = '0;
   int          xfers = 0;
   bit          rnd_rdy = 1'b0;

   function automatic logic [15:0] ref_onehot(input int i);
      logic [15:0] w;
      for (int k = 0; k < 16; k++) w[k] = (k == i);
      return w;
   endfunction

   function automatic logic [15:0] ref_therm(input int i);
      logic [15:0] w;
      for (int k = 0; k < 16; k++) w[k] = (k <= i);
      return w;
   endfunction

   // Handshakes are sampled mid-cycle; they describe the transfers of the next rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         am_mask    = '0;
         am_cnt     = 0;
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            chk("hold_valid", 64'(b4.out_valid), 64'd1);
            chk("hold_data", 64'({b4.out_word, b4.out_cnt}), 64'(stall_val));
         end
         stall_prev = b4.out_valid && !b4.out_ready;
         stall_val  = {b4.out_word, b4.out_cnt};
         if (b4.out_valid && b4.out_ready) begin
            chk("queue_nonempty", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
               pe = q.pop_front();
               chk("model_word", 64'(b4.out_word), 64'(pe.word));
               chk("model_cnt", 64'(b4.out_cnt), 64'(pe.cnt));
               xfers++;
            end
         end
         if (b4.in_valid && b4.in_ready) begin
            case (b4.mode)
               2'b01: begin
                  ne.word = ref_therm(int'(b4.in_idx));
                  ne.cnt  = 5'd1;
                  q.push_back(ne);
               end
               2'b10: begin
                  am_mask = am_mask | ref_onehot(int'(b4.in_idx));
                  am_cnt  = (am_cnt < 31) ? am_cnt + 1 : 31;
                  if (b4.in_last) begin
                     ne.word = am_mask;
                     ne.cnt  = 5'(am_cnt);
                     q.push_back(ne);
                     am_mask = '0;
                     am_cnt  = 0;
                  end
               end
               default: begin
                  ne.word = ref_onehot(int'(b4.in_idx));
                  ne.cnt  = 5'd1;
                  q.push_back(ne);
               end
            endcase
         end
      end
   end

   // ---------------- drive helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_rdy) b4.out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send4(input logic [1:0] m, input logic [3:0] i, input logic l);
      bit rdy;
      b4.in_valid = 1'b1;
      b4.mode     = m;
      b4.in_idx   = i;
      b4.in_last  = l;
      for (int n = 0; n < 100; n++) begin
         rdy = b4.in_ready;
         tick();
         if (rdy) return;
      end
      checks++;
      failures++;
      $display("FAIL send_timeout: beat mode=%0d idx=%0d not accepted within 100 cycles", m, i);
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic [3:0]  idx;
      logic        last;
      bit          prod;
      logic [15:0] word;
      logic [4:0]  cnt;
   } vec_t;

   vec_t tv[$];
   vec_t v;

   task automatic add_vec(input logic [1:0] m, input logic [3:0] i, input logic l,
                          input bit p, input logic [15:0] w, input logic [4:0] c);
      vec_t t;
      t.mode = m; t.idx = i; t.last = l; t.prod = p; t.word = w; t.cnt = c;
      tv.push_back(t);
   endtask

   int          x0;
   logic [63:0] idx6 [4];

   initial begin
      b4.in_valid = 1'b0; b4.in_idx = '0; b4.in_last = 1'b0; b4.mode = 2'b00; b4.out_ready = 1'b0;
      b6.in_valid = 1'b0; b6.in_idx = '0; b6.in_last = 1'b0; b6.mode = 2'b00; b6.out_ready = 1'b0;

      for (int i = 0; i < 16; i++) add_vec(2'b00, 4'(i), 1'b0, 1'b1, 16'd1 << i, 5'd1);
      add_vec(2'b01, 4'd0,  1'b0, 1'b1, 16'h0001, 5'd1);
      add_vec(2'b01, 4'd7,  1'b0, 1'b1, 16'h00FF, 5'd1);
      add_vec(2'b01, 4'd15, 1'b0, 1'b1, 16'hFFFF, 5'd1);
      add_vec(2'b01, 4'd3,  1'b0, 1'b1, 16'h000F, 5'd1);
      add_vec(2'b10, 4'd3,  1'b0, 1'b0, 16'h0000, 5'd0);
      add_vec(2'b10, 4'd9,  1'b0, 1'b0, 16'h0000, 5'd0);
      add_vec(2'b00, 4'd4,  1'b0, 1'b1, 16'h0010, 5'd1);
      add_vec(2'b10, 4'd0,  1'b1, 1'b1, 16'h0209, 5'd3);
      add_vec(2'b11, 4'd5,  1'b0, 1'b1, 16'h0020, 5'd1);

      // Reset state
      #12;
      chk("rst_out_valid", 64'(b4.out_valid), 64'd0);
      chk("rst_in_ready",  64'(b4.in_ready),  64'd0);
      chk("rst_out_word",  64'(b4.out_word),  64'd0);
      chk("rst_out_cnt",   64'(b4.out_cnt),   64'd0);
      chk("rst6_out_valid", 64'(b6.out_valid), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("ready_before_edge", 64'(b4.in_ready), 64'd0);
      tick();
      chk("ready_after_edge", 64'(b4.in_ready), 64'd1);

      // Table vectors, back-to-back with the sink always ready
      b4.out_ready = 1'b1;
      foreach (tv[n]) begin
         v = tv[n];
         b4.in_valid = 1'b1; b4.mode = v.mode; b4.in_idx = v.idx; b4.in_last = v.last;
         chk("tbl_ready", 64'(b4.in_ready), 64'd1);
         tick();
         chk("tbl_valid", 64'(b4.out_valid), 64'(v.prod));
         if (v.prod) begin
            chk("tbl_word", 64'(b4.out_word), 64'(v.word));
            chk("tbl_cnt",  64'(b4.out_cnt),  64'(v.cnt));
         end
      end
      b4.in_valid = 1'b0;
      tick();

      // Backpressure: two words fill main+skid, third waits
      x0 = xfers;
      b4.out_ready = 1'b0;
      b4.in_valid = 1'b1; b4.mode = 2'b00; b4.in_last = 1'b0; b4.in_idx = 4'd1;
      tick();
      b4.in_idx = 4'd2;
      tick();
      chk("bp_ready_low", 64'(b4.in_ready), 64'd0);
      chk("bp_head_word", 64'(b4.out_word), 64'h0002);
      b4.in_idx = 4'd3;
      tick();
      chk("bp_ready_still_low", 64'(b4.in_ready), 64'd0);
      b4.out_ready = 1'b1;
      send4(2'b00, 4'd3, 1'b0);
      b4.in_valid = 1'b0;
      repeat (4) tick();
      chk("bp_xfers", 64'(xfers - x0), 64'd3);
      chk("bp_queue_empty", 64'(q.size()), 64'd0);

      // Counter saturation over a long group
      for (int n = 0; n < 35; n++) send4(2'b10, 4'(n % 16), 1'b0);
      send4(2'b10, 4'd5, 1'b1);
      b4.in_valid = 1'b0;
      chk("sat_valid", 64'(b4.out_valid), 64'd1);
      chk("sat_word",  64'(b4.out_word),  64'hFFFF);
      chk("sat_cnt",   64'(b4.out_cnt),   64'd31);
      tick();

      // Randomized stream with random backpressure
      rnd_rdy = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 4) == 0) begin
            b4.in_valid = 1'b0;
            b4.mode     = 2'($urandom_range(0, 3));
            b4.in_idx   = 4'($urandom_range(0, 15));
            tick();
         end else begin
            send4(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
         end
      end
      b4.in_valid = 1'b0;
      rnd_rdy = 1'b0;
      b4.out_ready = 1'b1;
      repeat (5) tick();
      chk("rnd_queue_empty", 64'(q.size()), 64'd0);

      // Reset with a stalled word and a partial group
      b4.out_ready = 1'b0;
      send4(2'b00, 4'd7, 1'b0);
      send4(2'b10, 4'd1, 1'b0);
      send4(2'b10, 4'd2, 1'b0);
      b4.in_valid = 1'b0;
      chk("pre_rst_valid", 64'(b4.out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(b4.out_valid), 64'd0);
      chk("mid_rst_ready", 64'(b4.in_ready),  64'd0);
      chk("mid_rst_cnt",   64'(b4.out_cnt),   64'd0);
      #5;
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready", 64'(b4.in_ready), 64'd1);
      b4.out_ready = 1'b1;
      send4(2'b10, 4'd1, 1'b1);
      b4.in_valid = 1'b0;
      chk("post_rst_valid", 64'(b4.out_valid), 64'd1);
      chk("post_rst_word",  64'(b4.out_word),  64'h0002);
      chk("post_rst_cnt",   64'(b4.out_cnt),   64'd1);
      tick();

      // IN_W=6 block mask: 0,5,5,63 then a fresh group
      idx6[0] = 64'd0; idx6[1] = 64'd5; idx6[2] = 64'd5; idx6[3] = 64'd63;
      b6.out_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         b6.in_valid = 1'b1; b6.mode = 2'b10; b6.in_idx = 6'(idx6[n]); b6.in_last = (n == 3);
         chk("w6_ready", 64'(b6.in_ready), 64'd1);
         tick();
         chk("w6_valid", 64'(b6.out_valid), 64'(n == 3));
      end
      chk("w6_word", b6.out_word, 64'h8000_0000_0000_0021);
      chk("w6_cnt",  64'(b6.out_cnt), 64'd4);
      b6.in_idx = 6'd2; b6.in_last = 1'b1;
      tick();
      b6.in_valid = 1'b0;
      chk("w6_next_valid", 64'(b6.out_valid), 64'd1);
      chk("w6_next_word",  b6.out_word, 64'h4);
      chk("w6_next_cnt",   64'(b6.out_cnt), 64'd1);
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
